// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam int          FIFO_DEPTH        = 2;
  localparam int          DEFAULT_N         = 32;
  localparam int          DEFAULT_R         = 7;

  // One fetch buffer slot at the default widths: {pc, instr}
  typedef struct packed {
    logic [DEFAULT_R-1:0] pc;
    logic [DEFAULT_N-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry synchronous fetch buffer with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W = DEFAULT_R + DEFAULT_N
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  // Storage, pointers and occupancy; flush wins over push/pop, caller never overflows/underflows
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and fetch FSM feeding decode; FETCH_PERF_EN adds fetch/stall counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int           n         = 32,
  parameter int           r         = 7,
  parameter logic [n-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic         clk,
  input  logic         rstn,
  output logic [r-1:0] readAddr,
  input  logic [n-1:0] instr,
  input  logic         redirect,
  input  logic [r-1:0] redirectPC,
  output logic         idValid,
  input  logic         idReady,
  output logic [n-1:0] idInstr,
  output logic [r-1:0] idPC,
`ifdef FETCH_PERF_EN
  output logic [15:0]  fetchCount,
  output logic [15:0]  stallCount,
`endif
  output logic         halted
);

  fetch_state_t     r_state;
  fetch_state_t     w_next_state;
  logic [r-1:0]     r_pc;
  logic [r-1:0]     w_pc_next;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_space;
  logic [1:0]       w_count;
  logic [r+n-1:0]   w_head;

  // A redirect cycle never presents a transferable head
  assign idValid = (w_count != 2'd0) && !redirect;
  assign w_pop   = idValid && idReady;
  // Room exists if not full, or if the head leaves this same cycle
  assign w_space = (w_count < 2'(FIFO_DEPTH)) || w_pop;

  // State and PC register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
    end
  end

  // Next state, next PC, push and flush; redirect outranks everything outside IDLE
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      ST_IDLE: w_next_state = ST_RUN;
      ST_RUN: begin
        if (redirect) begin
          w_flush   = 1'b1;
          w_pc_next = redirectPC;
        end else if (w_space) begin
          w_push = 1'b1;
          if (instr == HALT_WORD) w_next_state = ST_HALTED;
          else                    w_pc_next    = r_pc + 1'b1;
        end
      end
      ST_HALTED: begin
        if (redirect) begin
          w_flush      = 1'b1;
          w_pc_next    = redirectPC;
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  fetch_fifo #(.W(r + n)) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (w_push),
    .i_push_data ({r_pc, instr}),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign readAddr = r_pc;
  assign idInstr  = w_head[n-1:0];
  assign idPC     = w_head[r+n-1:n];
  assign halted   = (r_state == ST_HALTED);

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_stall_count;

  // Pushes and idle RUN cycles, both free-running with natural 16-bit wrap
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fetch_count <= 16'd0;
      r_stall_count <= 16'd0;
    end else begin
      if (w_push) r_fetch_count <= r_fetch_count + 16'd1;
      if ((r_state == ST_RUN) && !w_push && !redirect) r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign fetchCount = r_fetch_count;
  assign stallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (vector table, corner sequences, random vs queue model)
module tb_fetch_unit;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clk;
  logic        rstn;
  logic [6:0]  readAddr;
  logic [31:0] instr;
  logic        redirect;
  logic [6:0]  redirectPC;
  logic        idValid;
  logic        idReady;
  logic [31:0] idInstr;
  logic [6:0]  idPC;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetchCount;
  logic [15:0] stallCount;
`endif

  logic [31:0] mem [128];
  assign instr = mem[readAddr];

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .readAddr   (readAddr),
    .instr      (instr),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .idValid    (idValid),
    .idReady    (idReady),
    .idInstr    (idInstr),
    .idPC       (idPC),
`ifdef FETCH_PERF_EN
    .fetchCount (fetchCount),
    .stallCount (stallCount),
`endif
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release (DUT still IDLE)
  task automatic reset_dut();
    rstn = 1'b0; redirect = 1'b0; redirectPC = '0; idReady = 1'b0;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [6:0]  rpc;
    logic        v;
    logic [31:0] ins;
    logic [6:0]  pc;
    logic [6:0]  addr;
    logic        h;
  } vec_t;

  typedef struct {
    int          pc;
    logic [31:0] ins;
  } ent_t;

  vec_t tbl [11];
  ent_t q [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[4] = 32'h55; mem[5] = HW;     mem[7'h40] = 32'hA0A0_0040; mem[127] = 32'h7F7F_007F;

    // Startup latency, streaming, halt delivery, release by redirect to 0
    tbl[0]  = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,  7'd0, 7'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,  7'd0, 7'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h11, 7'd0, 7'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h22, 7'd1, 7'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h33, 7'd2, 7'd3, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h44, 7'd3, 7'd4, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h55, 7'd4, 7'd5, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 7'd0, 1'b1, HW,     7'd5, 7'd5, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 7'd0, 1'b0, 32'h0,  7'd0, 7'd5, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,  7'd0, 7'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h11, 7'd0, 7'd1, 1'b0};

    reset_dut();
    chk("reset_idInstr", idInstr, 32'h0);
    chk("reset_idPC", 32'(idPC), 32'h0);
    for (int i = 0; i < 11; i++) begin
      idReady = tbl[i].rdy; redirect = tbl[i].redir; redirectPC = tbl[i].rpc;
      #1;
      chk($sformatf("vec%0d_idValid", i), 32'(idValid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_readAddr", i), 32'(readAddr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(tbl[i].h));
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_idInstr", i), idInstr, tbl[i].ins);
        chk($sformatf("vec%0d_idPC", i), 32'(idPC), 32'(tbl[i].pc));
      end
      next_cycle();
    end
    redirect = 1'b0;

    // Backpressure: buffer fills, PC freezes at 2, head stable
    reset_dut();
    idReady = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      chk("stall_readAddr", 32'(readAddr), 32'd2);
      chk("stall_idValid", 32'(idValid), 32'd1);
      chk("stall_idInstr", idInstr, 32'h11);
      chk("stall_idPC", 32'(idPC), 32'd0);
      next_cycle();
    end
    idReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_idValid", 32'(idValid), 32'd1);
      chk("drain_idInstr", idInstr, mem[k]);
      chk("drain_idPC", 32'(idPC), 32'(k));
      next_cycle();
    end

    // Redirect while full
    idReady = 1'b0;
    next_cycle();
    chk("full_before_redirect", 32'(idValid), 32'd1);
    redirect = 1'b1; redirectPC = 7'h40; idReady = 1'b1;
    #1;
    chk("redir_cycle_idValid", 32'(idValid), 32'd0);
    next_cycle();
    redirect = 1'b0;
    #1;
    chk("redir_k1_readAddr", 32'(readAddr), 32'h40);
    chk("redir_k1_idValid", 32'(idValid), 32'd0);
    next_cycle();
    chk("redir_k2_idValid", 32'(idValid), 32'd1);
    chk("redir_k2_idPC", 32'(idPC), 32'h40);
    chk("redir_k2_idInstr", idInstr, mem[7'h40]);

    // PC wrap 127 -> 0 -> 1
    redirect = 1'b1; redirectPC = 7'd127;
    next_cycle();
    redirect = 1'b0;
    #1;
    chk("wrap_readAddr", 32'(readAddr), 32'd127);
    next_cycle();
    chk("wrap_pc127", 32'(idPC), 32'd127);
    chk("wrap_instr127", idInstr, mem[127]);
    next_cycle();
    chk("wrap_pc0", 32'(idPC), 32'd0);
    next_cycle();
    chk("wrap_pc1", 32'(idPC), 32'd1);
    chk("wrap_valid", 32'(idValid), 32'd1);

    // Reset mid-stream with a full buffer and a concurrent redirect
    idReady = 1'b0;
    next_cycle();
    next_cycle();
    chk("pre_reset_idValid", 32'(idValid), 32'd1);
    rstn = 1'b0; redirect = 1'b1; redirectPC = 7'h33;
    next_cycle();
    redirect = 1'b0;
    #1;
    chk("midrst_readAddr", 32'(readAddr), 32'd0);
    chk("midrst_idValid", 32'(idValid), 32'd0);
    chk("midrst_idInstr", idInstr, 32'd0);
    chk("midrst_idPC", 32'(idPC), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_EN
    chk("midrst_fetchCount", 32'(fetchCount), 32'd0);
    chk("midrst_stallCount", 32'(stallCount), 32'd0);
`endif
    rstn = 1'b1;

    // Random traffic against a queue-based model of the fetch rules
    for (int i = 0; i < 128; i++) mem[i] = ($urandom_range(0, 9) == 0) ? HW : $urandom;
    reset_dut();
    begin
      bit m_started = 1'b0;
      bit m_halt    = 1'b0;
      int m_pc      = 0;
      bit exp_valid;
      q.delete();
      for (int cyc = 0; cyc < 2000; cyc++) begin
        idReady    = ($urandom_range(0, 3) != 0);
        redirect   = ($urandom_range(0, 11) == 0);
        redirectPC = 7'($urandom_range(0, 127));
        #1;
        exp_valid = (q.size() != 0) && !redirect;
        chk("rnd_idValid", 32'(idValid), 32'(exp_valid));
        chk("rnd_readAddr", 32'(readAddr), 32'(m_pc));
        chk("rnd_halted", 32'(halted), 32'(m_halt));
        if (exp_valid && idValid) begin
          chk("rnd_idInstr", idInstr, q[0].ins);
          chk("rnd_idPC", 32'(idPC), 32'(q[0].pc));
        end
        if (!m_started) begin
          m_started = 1'b1;
        end else if (redirect) begin
          q.delete();
          m_pc   = int'(redirectPC);
          m_halt = 1'b0;
        end else begin
          if (exp_valid && idReady) void'(q.pop_front());
          if (!m_halt && q.size() < 2) begin
            q.push_back('{m_pc, mem[m_pc]});
            if (mem[m_pc] == HW) m_halt = 1'b1;
            else                 m_pc   = (m_pc + 1) % 128;
          end
        end
        next_cycle();
      end
    end
    redirect = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the 32-bit read-only instruction memory and downstream-facing to decode. Owns the program counter, drives the memory's word address, captures the returned instruction with its PC into a 2-entry fetch buffer, and presents it to decode over a valid/ready handshake. Handles control-flow redirects (branch/jump) and stops fetching on a halt word.

## Interface

Parameters:
- `n`, 32, instruction width in bits (matches instruction memory data width).
- `r`, 7, word-address width (instruction memory depth is 2**r words).
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `readAddr`  out  r  word address to instruction memory; equals the PC register.
- `instr`  in  n  instruction returned combinationally by memory for `readAddr` in the same cycle.
- `redirect`  in  1  control-flow change requested by a later stage.
- `redirectPC`  in  r  word-address target of the redirect.
- `idValid`  out  1  buffer head holds a valid instruction for decode.
- `idReady`  in  1  decode accepts the head this cycle.
- `idInstr`  out  n  head instruction.
- `idPC`  out  r  word address of the head instruction.
- `halted`  out  1  fetch FSM is in HALTED.

## Operation

- FSM states: IDLE, RUN, HALTED. Encoded as a package enum.
- IDLE: entered on reset; no fetch. Next edge -> RUN.
- RUN: each cycle, push {readAddr, instr} if buffer has space after this cycle's pop (count < 2, or count == 2 with a pop). On push, PC <= PC + 1 modulo 2**r (127 -> 0 at default r). No push -> PC holds.
- When a pushed instruction equals `HALT_WORD`: it is still buffered and delivered; PC holds; RUN -> HALTED.
- HALTED: no fetch; buffer continues draining to decode. Only `redirect` leaves HALTED (-> RUN).
- Redirect (any state except IDLE; ignored in IDLE): buffer flushed (count <= 0), PC <= `redirectPC`, no push that cycle, state -> RUN. Redirect has priority over push, pop and halt detection in that cycle.
- Handshake: `idValid` = (count != 0) && !`redirect`. A pop occurs when `idValid` && `idReady`. Decode must not treat a redirect-cycle head as transferred.
- `idInstr`/`idPC` stable while `idValid` high and `idReady` low.
- Simultaneous push and pop at count 2: allowed, count stays 2, order preserved. At count 1: count stays 1, new entry becomes head next cycle.
- Buffer ordering strictly FIFO; no entry is ever dropped except by redirect flush.

## Timing

- Reset (rstn low at an edge): PC = 0, count = 0, state = IDLE, storage entries = 0; hence `readAddr` = 0, `idValid` = 0, `idInstr` = 0, `idPC` = 0, `halted` = 0. Reset mid-operation discards buffer and redirect unconditionally.
- First rstn-high edge: IDLE -> RUN. Next cycle fetches address 0; `idValid` high the cycle after (2 cycles after leaving reset).
- Fetch-to-decode latency: 1 cycle (instruction sampled at edge, visible as head next cycle when buffer was empty).
- Redirect asserted in cycle k: cycle k+1 `readAddr` = `redirectPC`, `idValid` = 0; cycle k+2 head = target instruction.
- Throughput: 1 instruction/cycle with `idReady` held high.
- `halted` is a registered state decode; rises the cycle after the halt word is pushed.

## Configuration

- `FETCH_PERF_EN` defined: adds outputs `fetchCount` (16 bits, increments per push) and `stallCount` (16 bits, increments each RUN cycle with no push and no redirect); both reset to 0, wrap at 16'hFFFF -> 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure

- Package `fetch_pkg`: FSM state enum, default `HALT_WORD` constant, buffer-entry struct {pc, instr}, buffer depth constant (2).
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO with push, pop, flush, count, head outputs; flush beats push/pop.

## Test plan

- Reset then `idReady`=1, memory words 0..3 = 0x11,0x22,0x33,0x44 -> `idValid` rises 2 cycles after reset release; `idInstr` sequence 0x11,0x22,0x33,0x44 with `idPC` 0,1,2,3 on consecutive cycles.
- `idReady`=0 for 5 cycles -> count saturates at 2, `readAddr` holds at 2, head stays 0x11/PC 0; release -> 0x11,0x22,0x33 delivered in order, no duplicates or gaps.
- Redirect to 0x40 while buffer full -> `idValid`=0 that cycle, next cycle `readAddr`=0x40, following cycle `idPC`=0x40.
- Word 5 = `HALT_WORD` -> halt word delivered with `idPC`=5, `halted`=1, `readAddr` frozen at 5; redirect to 0 -> `halted`=0, refetch from 0.
- PC wrap: redirect to 127 -> `idPC` sequence 127, 0, 1.
- Assert `rstn`=0 mid-stream with full buffer -> next cycle all outputs at reset values; with `FETCH_PERF_EN`, counters read 0.
